// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the hardware call/data stack.
//   state_t             : control FSM states (ST_RUN, ST_ERROR)
//   OP_PUSH / OP_POP    : {push, pop} request encodings used by the decoder
//   SP_TOP_DEFAULT      : byte address reported when the stack is empty
//   WORD_BYTES_DEFAULT  : stack-pointer step per pushed/popped word
// ---------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b01;

  localparam logic [15:0] SP_TOP_DEFAULT     = 16'hFFFE;
  localparam int          WORD_BYTES_DEFAULT = 2;

endpackage

// File: rtl/stack_ram.sv
// ---------------------------------------------------------------------------
// stack_ram
// DEPTH x WIDTH register array backing the stack. Contents are deliberately
// not reset; the owner tracks which entries are meaningful.
// Ports:
//   clk        in   write clock (rising edge)
//   i_we       in   write enable
//   i_wr_addr  in   write index
//   i_wr_data  in   word to store
//   i_rd_addr  in   read index
//   o_rd_data  out  combinational read of entry i_rd_addr
// ---------------------------------------------------------------------------
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single synchronous write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
// Parametrised hardware stack with byte-addressed SP export, sticky
// overflow/underflow detection, a registered pop path, same-cycle
// push+pop replace and synchronous flush.
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   push, pop          operation requests for this cycle
//   push_data          word to push
//   flush              empty the stack (wins over push/pop)
//   clear_err          return from ERROR to RUN, clearing sticky flags
//   pop_data           registered popped word
//   pop_valid          one-cycle pulse following an accepted pop/replace
//   top_data           current top entry, 0 when empty
//   currentSP          SP_TOP - count*WORD_BYTES (mod 2^ADDR_W)
//   count              occupancy
//   empty, full        derived from count
//   overflow           sticky, push while full
//   underflow          sticky, pop while empty
//   high_water         (STACK_WATERMARK_EN only) max count since reset/flush
// Optional feature macro: STACK_WATERMARK_EN
// ---------------------------------------------------------------------------
module stack_unit
  import stack_pkg::*;
#(
  parameter int                 WIDTH      = 16,
  parameter int                 DEPTH      = 16,
  parameter int                 ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  SP_TOP     = ADDR_W'(SP_TOP_DEFAULT),
  parameter int                 WORD_BYTES = WORD_BYTES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         top_data,
  output logic [ADDR_W-1:0]        currentSP,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
`ifdef STACK_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0]   high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_popData;
  logic             r_popValid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;
  logic             w_doReplace;
  logic             w_ovfEvt;
  logic             w_unfEvt;
  logic [CW-1:0]    w_countNext;
  logic [AW-1:0]    w_topAddr;
  logic [AW-1:0]    w_wrAddr;
  logic             w_we;
  logic [WIDTH-1:0] w_rdData;
  logic [ADDR_W-1:0] w_spOffset;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_topAddr = AW'(r_count - CW'(1));

  // Operation decode. Flush and the ERROR state both suppress push/pop, so
  // no events can be raised while either holds. Push+pop on an empty stack
  // degenerates to a plain push; on a full stack it is a legal replace.
  always_comb begin
    w_doPush    = 1'b0;
    w_doPop     = 1'b0;
    w_doReplace = 1'b0;
    w_ovfEvt    = 1'b0;
    w_unfEvt    = 1'b0;
    if (!flush && r_state == ST_RUN) begin
      case ({push, pop})
        OP_PUSH: begin
          if (w_full) w_ovfEvt = 1'b1;
          else        w_doPush = 1'b1;
        end
        OP_POP: begin
          if (w_empty) w_unfEvt = 1'b1;
          else         w_doPop  = 1'b1;
        end
        OP_PUSH | OP_POP: begin
          if (w_empty) w_doPush    = 1'b1;
          else         w_doReplace = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next occupancy; shared by the count register and the watermark
  always_comb begin
    w_countNext = r_count;
    if (flush)         w_countNext = '0;
    else if (w_doPush) w_countNext = r_count + CW'(1);
    else if (w_doPop)  w_countNext = r_count - CW'(1);
  end

  // A replace overwrites the current top; a push writes the next free slot
  assign w_we     = w_doPush | w_doReplace;
  assign w_wrAddr = w_doReplace ? w_topAddr : AW'(r_count);

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_addr (w_wrAddr),
    .i_wr_data (push_data),
    .i_rd_addr (w_topAddr),
    .o_rd_data (w_rdData)
  );

  // Control FSM with registered outputs. clear_err is looked at only in
  // ERROR and is independent of flush, which never touches flags or state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_count     <= '0;
      r_popData   <= '0;
      r_popValid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      r_popValid <= w_doPop | w_doReplace;
      if (w_doPop || w_doReplace) begin
        r_popData <= w_rdData;
      end
      case (r_state)
        ST_RUN: begin
          if (w_ovfEvt) begin
            r_overflow <= 1'b1;
            r_state    <= ST_ERROR;
          end
          if (w_unfEvt) begin
            r_underflow <= 1'b1;
            r_state     <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (clear_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef STACK_WATERMARK_EN
  logic [CW-1:0] r_highWater;

  // Tracks the peak of the next count so it moves on the same edge as count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_highWater <= '0;
    end else if (flush) begin
      r_highWater <= '0;
    end else if (w_countNext > r_highWater) begin
      r_highWater <= w_countNext;
    end
  end

  assign high_water = r_highWater;
`endif

  // SP arithmetic wraps naturally at ADDR_W bits
  assign w_spOffset = ADDR_W'(r_count) * ADDR_W'(WORD_BYTES);
  assign currentSP  = SP_TOP - w_spOffset;

  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign top_data  = w_empty ? '0 : w_rdData;
  assign pop_data  = r_popData;
  assign pop_valid = r_popValid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit (default parameters). A queue-based
// reference stack predicts every visible output.
// ---------------------------------------------------------------------------
module tb_stack_unit;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [15:0] pushData;
  logic        flush;
  logic        clearErr;
  logic [15:0] popData;
  logic        popValid;
  logic [15:0] topData;
  logic [15:0] currentSP;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
`ifdef STACK_WATERMARK_EN
  logic [4:0]  highWater;
`endif

  int checks;
  int errors;

  // Reference model state
  logic [15:0] mdl[$];
  bit          mErr;
  bit          mOvf;
  bit          mUnf;
  logic [15:0] mPopData;
  bit          mPopValid;
  int          mHw;

  stack_unit dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pushData),
    .flush     (flush),
    .clear_err (clearErr),
    .pop_data  (popData),
    .pop_valid (popValid),
    .top_data  (topData),
    .currentSP (currentSP),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef STACK_WATERMARK_EN
    ,
    .high_water(highWater)
`endif
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] expSP();
    return 16'hFFFE - 16'(2 * mdl.size());
  endfunction

  function automatic logic [15:0] expTop();
    return (mdl.size() == 0) ? 16'h0000 : mdl[mdl.size()-1];
  endfunction

  // Reference model: one clock of stack behaviour from the rules
  task automatic modelStep(input bit p, input bit o, input logic [15:0] d,
                           input bit f, input bit c);
    bit wasErr;
    wasErr    = mErr;
    mPopValid = 0;
    if (f) begin
      mdl.delete();
      mHw = 0;
    end else if (!wasErr) begin
      if (p && !o) begin
        if (mdl.size() == DEPTH) begin
          mOvf = 1;
          mErr = 1;
        end else begin
          mdl.push_back(d);
        end
      end else if (o && !p) begin
        if (mdl.size() == 0) begin
          mUnf = 1;
          mErr = 1;
        end else begin
          mPopData  = mdl.pop_back();
          mPopValid = 1;
        end
      end else if (p && o) begin
        if (mdl.size() == 0) begin
          mdl.push_back(d);
        end else begin
          mPopData  = mdl[mdl.size()-1];
          mdl[mdl.size()-1] = d;
          mPopValid = 1;
        end
      end
    end
    if (wasErr && c) begin
      mErr = 0;
      mOvf = 0;
      mUnf = 0;
    end
    if (mdl.size() > mHw) mHw = mdl.size();
  endtask

  task automatic modelReset();
    mdl.delete();
    mErr      = 0;
    mOvf      = 0;
    mUnf      = 0;
    mPopData  = 16'h0000;
    mPopValid = 0;
    mHw       = 0;
  endtask

  // Drive one cycle of inputs, clock it, sample #1 after the edge
  task automatic applyStimulus(input bit p, input bit o, input logic [15:0] d,
                               input bit f, input bit c);
    push     = p;
    pop      = o;
    pushData = d;
    flush    = f;
    clearErr = c;
    @(posedge clk);
    #1;
    modelStep(p, o, d, f, c);
    push     = 0;
    pop      = 0;
    flush    = 0;
    clearErr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push = 0; pop = 0; pushData = '0; flush = 0; clearErr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
    checks++; if (currentSP !== 16'hFFFE) begin errors++; $display("[TB] FAIL reset_sp got %h exp FFFE", currentSP); end
    checks++; if (popData !== 16'h0 || popValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop got %h/%b exp 0000/0", popData, popValid); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b exp 00", overflow, underflow); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_empty_full got %b%b exp 10", empty, full); end
  endtask

  task automatic test_push_pop();
    logic [15:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, vals[i], 0, 0);
    checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL push3_count got %0d exp 3", count); end
    checks++; if (currentSP !== 16'hFFF8) begin errors++; $display("[TB] FAIL push3_sp got %h exp FFF8", currentSP); end
    checks++; if (topData !== 16'h0033) begin errors++; $display("[TB] FAIL push3_top got %h exp 0033", topData); end
    for (int i = 2; i >= 0; i--) begin
      applyStimulus(0, 1, 16'h0, 0, 0);
      checks++;
      if (popValid !== 1'b1 || popData !== vals[i]) begin
        errors++; $display("[TB] FAIL pop_data got %h/%b exp %h/1", popData, popValid, vals[i]);
      end
      applyStimulus(0, 0, 16'h0, 0, 0);
      checks++;
      if (popValid !== 1'b0) begin errors++; $display("[TB] FAIL pop_valid_pulse got %b exp 0", popValid); end
    end
    checks++; if (empty !== 1'b1 || currentSP !== 16'hFFFE) begin errors++; $display("[TB] FAIL pop3_empty got %b/%h exp 1/FFFE", empty, currentSP); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 16'h0100 + 16'(i), 0, 0);
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("[TB] FAIL fill got full=%b count=%0d exp 1/16", full, count); end
    applyStimulus(1, 0, 16'hDEAD, 0, 0);
    checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("[TB] FAIL overflow got ovf=%b count=%0d exp 1/16", overflow, count); end
    checks++; if (topData !== 16'h010F) begin errors++; $display("[TB] FAIL overflow_nowrite got %h exp 010F", topData); end
    applyStimulus(0, 1, 16'h0, 0, 0);
    checks++; if (count !== 5'd16 || popValid !== 1'b0) begin errors++; $display("[TB] FAIL error_pop_ignored got count=%0d pv=%b exp 16/0", count, popValid); end
    applyStimulus(0, 0, 16'h0, 0, 1);
    checks++; if (overflow !== 1'b0 || count !== 5'd16) begin errors++; $display("[TB] FAIL clear_err got ovf=%b count=%0d exp 0/16", overflow, count); end
    applyStimulus(0, 1, 16'h0, 0, 0);
    checks++; if (popData !== 16'h010F || popValid !== 1'b1) begin errors++; $display("[TB] FAIL pop_after_clear got %h/%b exp 010F/1", popData, popValid); end
  endtask

  task automatic test_underflow_replace();
    applyStimulus(0, 0, 16'h0, 1, 0);
    checks++; if (count !== 5'd0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre got count=%0d exp 0", count); end
    applyStimulus(0, 1, 16'h0, 0, 0);
    checks++; if (underflow !== 1'b1 || popValid !== 1'b0 || count !== 5'd0) begin errors++; $display("[TB] FAIL underflow got unf=%b pv=%b count=%0d exp 1/0/0", underflow, popValid, count); end
    applyStimulus(0, 0, 16'h0, 0, 1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL underflow_clear got %b exp 0", underflow); end
    applyStimulus(1, 1, 16'h0077, 0, 0);
    checks++; if (count !== 5'd1 || popValid !== 1'b0 || underflow !== 1'b0 || topData !== 16'h0077) begin errors++; $display("[TB] FAIL replace_empty got count=%0d pv=%b unf=%b top=%h exp 1/0/0/0077", count, popValid, underflow, topData); end
    applyStimulus(1, 0, 16'h0002, 0, 0);
    applyStimulus(1, 1, 16'h00AA, 0, 0);
    checks++; if (popData !== 16'h0002 || popValid !== 1'b1) begin errors++; $display("[TB] FAIL replace_pop got %h/%b exp 0002/1", popData, popValid); end
    checks++; if (topData !== 16'h00AA || count !== 5'd2) begin errors++; $display("[TB] FAIL replace_top got %h count=%0d exp 00AA/2", topData, count); end
  endtask

  task automatic test_flush();
    applyStimulus(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 16'h0500 + 16'(i), 0, 0);
    checks++; if (count !== 5'd5 || topData !== 16'h0504) begin errors++; $display("[TB] FAIL flush_fill got count=%0d top=%h exp 5/0504", count, topData); end
`ifdef STACK_WATERMARK_EN
    checks++; if (highWater !== 5'd5) begin errors++; $display("[TB] FAIL hw_before got %0d exp 5", highWater); end
`endif
    applyStimulus(1, 0, 16'hBEEF, 1, 0);
    checks++; if (count !== 5'd0 || currentSP !== 16'hFFFE || topData !== 16'h0) begin errors++; $display("[TB] FAIL flush got count=%0d sp=%h top=%h exp 0/FFFE/0000", count, currentSP, topData); end
    checks++; if (popValid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_flags got pv=%b ovf=%b exp 0/0", popValid, overflow); end
`ifdef STACK_WATERMARK_EN
    checks++; if (highWater !== 5'd0) begin errors++; $display("[TB] FAIL hw_after got %0d exp 0", highWater); end
`endif
  endtask

  task automatic test_random();
    int r;
    bit p, o, f, c;
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      p = (r < 45) || (r >= 75 && r < 85);
      o = (r >= 45 && r < 85);
      f = (r >= 85 && r < 88);
      c = ($urandom_range(0, 9) < 3);
      d = 16'($urandom_range(0, 65535));
      applyStimulus(p, o, d, f, c);
      checks++; if (count !== 5'(mdl.size())) begin errors++; $display("[TB] FAIL rnd_count cyc %0d got %0d exp %0d", n, count, mdl.size()); end
      checks++; if (currentSP !== expSP()) begin errors++; $display("[TB] FAIL rnd_sp cyc %0d got %h exp %h", n, currentSP, expSP()); end
      checks++; if (topData !== expTop()) begin errors++; $display("[TB] FAIL rnd_top cyc %0d got %h exp %h", n, topData, expTop()); end
      checks++; if (popValid !== mPopValid || popData !== mPopData) begin errors++; $display("[TB] FAIL rnd_pop cyc %0d got %h/%b exp %h/%b", n, popData, popValid, mPopData, mPopValid); end
      checks++; if (overflow !== mOvf || underflow !== mUnf) begin errors++; $display("[TB] FAIL rnd_flags cyc %0d got %b%b exp %b%b", n, overflow, underflow, mOvf, mUnf); end
      checks++; if (full !== (mdl.size() == DEPTH) || empty !== (mdl.size() == 0)) begin errors++; $display("[TB] FAIL rnd_full_empty cyc %0d got %b%b", n, full, empty); end
`ifdef STACK_WATERMARK_EN
      checks++; if (highWater !== 5'(mHw)) begin errors++; $display("[TB] FAIL rnd_hw cyc %0d got %0d exp %0d", n, highWater, mHw); end
`endif
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(0, 0, 16'h0, 1, 1);
    modelReset();
    applyStimulus(1, 0, 16'h1234, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0);
    push     = 1'b1;
    pushData = 16'h5678;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || currentSP !== 16'hFFFE || empty !== 1'b1) begin errors++; $display("[TB] FAIL async_reset got count=%0d sp=%h exp 0/FFFE", count, currentSP); end
    checks++; if (popValid !== 1'b0 || popData !== 16'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_regs got pd=%h pv=%b flags=%b%b", popData, popValid, overflow, underflow); end
    @(negedge clk);
    push  = 1'b0;
    reset = 1'b0;
    modelReset();
    applyStimulus(1, 0, 16'h00C3, 0, 0);
    checks++; if (count !== 5'd1 || topData !== 16'h00C3) begin errors++; $display("[TB] FAIL post_reset_push got count=%0d top=%h exp 1/00C3", count, topData); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelReset();
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow_replace();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised hardware call/data stack. Replaces the current fixed 16-bit SP register, the SP next-value mux and the stack path through data memory.
- Holds DEPTH words of WIDTH bits in private storage. Exports a byte-addressed stack pointer so the core can still display and use SP.
- Adds behaviour the current stack lacks: overflow/underflow detection, a sticky error state, a registered pop path, same-cycle push+pop replace, and flush.

Parameters:
- WIDTH, 16, data word width in bits (>=8).
- DEPTH, 16, number of stack entries (power of two, >=2).
- ADDR_W, 16, width of exported stack-pointer address.
- SP_TOP, 16'hFFFE, SP value when the stack is empty (byte address).
- WORD_BYTES, 2, SP step per push/pop.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  push request this cycle.
- pop  in  1  pop request this cycle.
- push_data  in  WIDTH  data to push.
- flush  in  1  empty the stack (synchronous).
- clear_err  in  1  leave ERROR state.
- pop_data  out  WIDTH  registered popped word.
- pop_valid  out  1  pulses 1 cycle after an accepted pop.
- top_data  out  WIDTH  combinational current top entry; 0 when empty.
- currentSP  out  ADDR_W  SP_TOP - count*WORD_BYTES.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set on push while full.
- underflow  out  1  sticky; set on pop while empty.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - count=0, currentSP=SP_TOP, pop_data=0, pop_valid=0, overflow=0, underflow=0, FSM=RUN.
  - Storage contents are not reset.
- FSM has two states, RUN and ERROR.
  - RUN -> ERROR on any overflow or underflow event.
  - ERROR -> RUN on clear_err (synchronous). Count is preserved; the sticky flags clear.
  - In ERROR, push and pop are ignored. Flush is still honoured.
- Accepted push (RUN, push=1, pop=0, not full): mem[count]<=push_data, count+1, SP decreases by WORD_BYTES.
- Accepted pop (RUN, pop=1, push=0, not empty): pop_data<=mem[count-1], count-1, SP increases by WORD_BYTES. pop_valid=1 on the next cycle only.
- Push and pop in the same cycle, not empty (replace):
  - pop_data<=old top, mem[count-1]<=push_data, count unchanged. pop_valid pulses.
  - When empty, this is treated as a plain push: no underflow, pop_valid stays 0.
- Push while full: no write, count unchanged, overflow<=1, enter ERROR.
- Pop while empty (no push): count unchanged, pop_data unchanged, underflow<=1, enter ERROR.
- Flush has priority over push/pop: count<=0, SP<=SP_TOP, pop_valid=0. Flags and FSM state are unchanged.
- Arithmetic: SP is computed modulo 2^ADDR_W. count never wraps. full/empty are derived from count and are never separately registered.
- Write latency is 1 cycle: top_data reflects a push on the cycle after it.

Optional Feature:
- Macro: STACK_WATERMARK_EN.
- Defined: adds output high_water ($clog2(DEPTH)+1 bits), the maximum count seen since reset or flush. It updates on the same edge as count. Reset value is 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package stack_pkg holds:
  - the FSM state typedef (ST_RUN, ST_ERROR);
  - op-encoding localparams for the core decoder (OP_PUSH, OP_POP);
  - the default SP_TOP and WORD_BYTES constants.
- One sub-module, stack_ram: a DEPTH x WIDTH register array with one synchronous write port and one combinational read port. stack_unit owns count, FSM, flags and the pop register.

Test Plan:
- Reset then 3 pushes (16'h0011, 16'h0022, 16'h0033) -> count=3, currentSP=16'hFFF8, top_data=16'h0033.
- 3 pops -> pop_data 16'h0033, 16'h0022, 16'h0011, each with a 1-cycle pop_valid pulse one cycle after its pop; then empty=1, currentSP=16'hFFFE.
- Fill to DEPTH=16, then push 16'hDEAD -> overflow=1, FSM=ERROR, count=16; a following pop is ignored; clear_err -> RUN, overflow=0; a pop then returns the 16th pushed value.
- Pop on empty -> underflow=1, pop_valid stays 0; simultaneous push 16'h00AA + pop with count=2 -> pop_data=old top, top_data=16'h00AA, count=2.
- Push 5 words, assert flush together with push -> count=0, currentSP=SP_TOP, no write occurs; with STACK_WATERMARK_EN, high_water reads 5 before the flush and 0 after.
- Assert reset asynchronously between clock edges mid-push -> all outputs return to reset values immediately, without waiting for a clock edge.
